// File: rtl/CONFIG.sv
`default_nettype none
// ============================================================================
//  Package     : CONFIG
//  Description : Shared build-time constants for the synthesiser core.
//                PERIOD_WIDTH is the width of an oscillator period word.
//  Revision    : 1.0 - initial release
// ============================================================================
package CONFIG;
    localparam int PERIOD_WIDTH = 16;
endpackage
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice allocator. Accepts note-on/note-off events
//                and maps them onto VOICES oscillator voices. A note-on
//                retriggers a voice already holding the note, otherwise takes
//                the lowest free voice, otherwise steals the oldest voice.
//                Each event takes IDLE -> LOOKUP -> APPLY; voice outputs
//                change two edges after acceptance.
//  Ports       : clock_50_000_000 - system clock (rising edge)
//                reset_l          - asynchronous active-low reset
//                all_notes_off    - synchronous panic, releases all voices
//                note_valid/ready - event handshake (ready only in IDLE)
//                note_on          - 1 = note-on, 0 = note-off
//                note_number      - MIDI note number
//                note_period      - oscillator period (note-on only)
//                voice_active     - per-voice sounding flag
//                voice_note       - per-voice note, 7 bits each
//                voice_period     - per-voice period, PERIOD_WIDTH each
//                voice_clear      - per-voice one-cycle phase restart pulse
//                steal            - one-cycle pulse when a voice is stolen
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES       = 4,
    parameter int PERIOD_WIDTH = CONFIG::PERIOD_WIDTH,
    parameter int AGE_WIDTH    = 8
) (
    input  logic                             clock_50_000_000,
    input  logic                             reset_l,
    input  logic                             all_notes_off,
    input  logic                             note_valid,
    output logic                             note_ready,
    input  logic                             note_on,
    input  logic [6:0]                       note_number,
    input  logic [PERIOD_WIDTH-1:0]          note_period,
    output logic [VOICES-1:0]                voice_active,
    output logic [VOICES*7-1:0]              voice_note,
    output logic [VOICES*PERIOD_WIDTH-1:0]   voice_period,
    output logic [VOICES-1:0]                voice_clear,
    output logic                             steal
);

    localparam int                   c_IDX_W   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AGE_WIDTH-1:0] c_AGE_MAX = {AGE_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        APPLY  = 2'd2
    } state_t;

    state_t                  r_state;

    // Latched event
    logic                    r_ev_on;
    logic [6:0]              r_ev_note;
    logic [PERIOD_WIDTH-1:0] r_ev_period;

    // Voice state
    logic [VOICES-1:0]       r_active;
    logic [6:0]              r_note   [VOICES];
    logic [PERIOD_WIDTH-1:0] r_period [VOICES];
    logic [AGE_WIDTH-1:0]    r_age    [VOICES];
    logic [VOICES-1:0]       r_clear;
    logic                    r_steal;

    // Lookup results captured in LOOKUP, consumed in APPLY
    logic                    r_hit;
    logic [c_IDX_W-1:0]      r_hit_idx;
    logic                    r_free;
    logic [c_IDX_W-1:0]      r_free_idx;
    logic [c_IDX_W-1:0]      r_old_idx;

    // Combinational search results
    logic                    w_hit;
    logic [c_IDX_W-1:0]      w_hit_idx;
    logic                    w_free;
    logic [c_IDX_W-1:0]      w_free_idx;
    logic                    w_old_found;
    logic [c_IDX_W-1:0]      w_old_idx;
    logic [AGE_WIDTH-1:0]    w_old_age;
    logic [c_IDX_W-1:0]      w_tgt_idx;

    // Panic blocks acceptance so a held all_notes_off can never admit an event.
    assign note_ready   = (r_state == IDLE) && !all_notes_off;
    assign voice_active = r_active;
    assign voice_clear  = r_clear;
    assign steal        = r_steal;

    generate
        for (genvar g = 0; g < VOICES; g++) begin : g_out
            assign voice_note[g*7 +: 7]                       = r_note[g];
            assign voice_period[g*PERIOD_WIDTH +: PERIOD_WIDTH] = r_period[g];
        end
    endgenerate

    // Parallel search over all voices. Ascending scan with "found" guards
    // gives lowest-index priority; strict '>' keeps the lowest index on an
    // age tie.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_old_found = 1'b0;
        w_old_idx   = '0;
        w_old_age   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (r_active[i] && (r_note[i] == r_ev_note) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
            if (!r_active[i] && !w_free) begin
                w_free     = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
            if (r_active[i] && (!w_old_found || (r_age[i] > w_old_age))) begin
                w_old_found = 1'b1;
                w_old_idx   = c_IDX_W'(i);
                w_old_age   = r_age[i];
            end
        end
    end

    // Note-on target: retrigger beats free voice beats steal.
    assign w_tgt_idx = r_hit  ? r_hit_idx  :
                       r_free ? r_free_idx : r_old_idx;

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= IDLE;
            r_ev_on     <= 1'b0;
            r_ev_note   <= '0;
            r_ev_period <= '0;
            r_active    <= '0;
            r_clear     <= '0;
            r_steal     <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_free      <= 1'b0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
            for (int v = 0; v < VOICES; v++) begin
                r_note[v]   <= '0;
                r_period[v] <= '0;
                r_age[v]    <= '0;
            end
        end else begin
            // Pulses last exactly one cycle
            r_clear <= '0;
            r_steal <= 1'b0;
            if (all_notes_off) begin
                // Notes and periods hold; only sounding state and ages drop.
                r_state  <= IDLE;
                r_active <= '0;
                for (int v = 0; v < VOICES; v++) begin
                    r_age[v] <= '0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (note_valid && note_ready) begin
                            r_ev_on     <= note_on;
                            r_ev_note   <= note_number;
                            r_ev_period <= note_period;
                            r_state     <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        r_hit      <= w_hit;
                        r_hit_idx  <= w_hit_idx;
                        r_free     <= w_free;
                        r_free_idx <= w_free_idx;
                        r_old_idx  <= w_old_idx;
                        r_state    <= APPLY;
                    end
                    APPLY: begin
                        r_state <= IDLE;
                        if (r_ev_on) begin
                            for (int v = 0; v < VOICES; v++) begin
                                if (c_IDX_W'(v) == w_tgt_idx) begin
                                    r_active[v] <= 1'b1;
                                    r_note[v]   <= r_ev_note;
                                    r_period[v] <= r_ev_period;
                                    r_age[v]    <= '0;
                                    r_clear[v]  <= 1'b1;
                                end else if (r_active[v] && (r_age[v] != c_AGE_MAX)) begin
                                    r_age[v] <= r_age[v] + 1'b1;
                                end
                            end
                            r_steal <= !r_hit && !r_free;
                        end else if (r_hit) begin
                            for (int v = 0; v < VOICES; v++) begin
                                if (c_IDX_W'(v) == r_hit_idx) begin
                                    r_active[v] <= 1'b0;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Self-checking bench for voice_allocator. A behavioural voice
//                model produces the expected voice state for every event;
//                snapshots are queued when an event is driven and popped when
//                the DUT's outputs update.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int V  = 4;
    localparam int PW = 16;
    localparam int AW = 8;

    logic            clk;
    logic            reset_l;
    logic            all_notes_off;
    logic            note_valid;
    logic            note_ready;
    logic            note_on;
    logic [6:0]      note_number;
    logic [PW-1:0]   note_period;
    logic [V-1:0]    voice_active;
    logic [V*7-1:0]  voice_note;
    logic [V*PW-1:0] voice_period;
    logic [V-1:0]    voice_clear;
    logic            steal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string          tag;
        logic [V-1:0]   active;
        logic [V*7-1:0] notes;
        logic [V*PW-1:0] periods;
        logic [V-1:0]   clear;
        logic           steal;
    } exp_t;

    exp_t exp_q[$];

    // Reference voice model
    logic [V-1:0]  m_active;
    logic [6:0]    m_note   [V];
    logic [PW-1:0] m_period [V];
    int            m_age    [V];

    voice_allocator #(
        .VOICES       (V),
        .PERIOD_WIDTH (PW),
        .AGE_WIDTH    (AW)
    ) dut (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .all_notes_off    (all_notes_off),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_on          (note_on),
        .note_number      (note_number),
        .note_period      (note_period),
        .voice_active     (voice_active),
        .voice_note       (voice_note),
        .voice_period     (voice_period),
        .voice_clear      (voice_clear),
        .steal            (steal)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = '0;
        for (int i = 0; i < V; i++) begin
            m_note[i]   = '0;
            m_period[i] = '0;
            m_age[i]    = 0;
        end
    endtask

    function automatic exp_t model_snapshot(input string tag);
        exp_t e;
        e.tag    = tag;
        e.active = m_active;
        e.clear  = '0;
        e.steal  = 1'b0;
        for (int i = 0; i < V; i++) begin
            e.notes[i*7 +: 7]    = m_note[i];
            e.periods[i*PW +: PW] = m_period[i];
        end
        return e;
    endfunction

    // Applies one event to the model and queues the expected outputs.
    task automatic model_event(input string tag, input logic on, input logic [6:0] n,
                               input logic [PW-1:0] p);
        exp_t e;
        int   hit;
        int   free;
        int   old;
        int   tgt;
        logic stl;
        hit = -1; free = -1; old = -1; tgt = -1; stl = 1'b0;
        for (int i = 0; i < V; i++) begin
            if (m_active[i] && m_note[i] == n && hit < 0) hit = i;
            if (!m_active[i] && free < 0) free = i;
            if (m_active[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (on) begin
            tgt = (hit >= 0) ? hit : ((free >= 0) ? free : old);
            stl = (hit < 0) && (free < 0);
            for (int i = 0; i < V; i++) begin
                if (i != tgt && m_active[i] && m_age[i] < (2**AW - 1)) m_age[i]++;
            end
            m_active[tgt] = 1'b1;
            m_note[tgt]   = n;
            m_period[tgt] = p;
            m_age[tgt]    = 0;
        end else if (hit >= 0) begin
            m_active[hit] = 1'b0;
        end
        e = model_snapshot(tag);
        if (tgt >= 0) e.clear[tgt] = 1'b1;
        e.steal = stl;
        exp_q.push_back(e);
    endtask

    // Drives one event and checks the full handshake and output timing.
    task automatic send_event(input string tag, input logic on, input logic [6:0] n,
                              input logic [PW-1:0] p);
        exp_t e;
        @(negedge clk);
        check({tag, " ready_idle"}, note_ready, 1);
        note_valid  = 1'b1;
        note_on     = on;
        note_number = n;
        note_period = p;
        model_event(tag, on, n, p);
        @(negedge clk);
        note_valid = 1'b0;
        check({tag, " ready_lookup"}, note_ready, 0);
        @(negedge clk);
        check({tag, " ready_apply"}, note_ready, 0);
        check({tag, " clear_early"}, voice_clear, 0);
        check({tag, " steal_early"}, steal, 0);
        @(negedge clk);
        check({tag, " sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.tag, " active"}, voice_active, e.active);
            check({e.tag, " notes"},  voice_note,   e.notes);
            check({e.tag, " period"}, voice_period, e.periods);
            check({e.tag, " clear"},  voice_clear,  e.clear);
            check({e.tag, " steal"},  steal,        e.steal);
        end
        check({tag, " ready_back"}, note_ready, 1);
        @(negedge clk);
        check({tag, " clear_1cyc"}, voice_clear, 0);
        check({tag, " steal_1cyc"}, steal, 0);
    endtask

    task automatic check_model_state(input string tag);
        exp_t e;
        e = model_snapshot(tag);
        check({tag, " active"}, voice_active, e.active);
        check({tag, " notes"},  voice_note,   e.notes);
        check({tag, " period"}, voice_period, e.periods);
        check({tag, " clear"},  voice_clear,  0);
        check({tag, " steal"},  steal,        0);
    endtask

    initial begin
        reset_l       = 1'b0;
        all_notes_off = 1'b0;
        note_valid    = 1'b0;
        note_on       = 1'b0;
        note_number   = '0;
        note_period   = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset ready", note_ready, 1);
        check_model_state("reset");
        @(negedge clk);
        reset_l = 1'b1;

        // First note, then retrigger of the same note
        send_event("on60",       1'b1, 7'd60, 16'd1000);
        send_event("retrig60",   1'b1, 7'd60, 16'd500);

        // Fill remaining voices, then steal the oldest (voice 0)
        send_event("on62",       1'b1, 7'd62, 16'd2000);
        send_event("on64",       1'b1, 7'd64, 16'd3000);
        send_event("on67",       1'b1, 7'd67, 16'd4000);
        send_event("steal69",    1'b1, 7'd69, 16'd5000);

        // Note-off present and absent
        send_event("off62",      1'b0, 7'd62, 16'd0);
        send_event("off50",      1'b0, 7'd50, 16'd0);

        // Freed voice 1 is reused; then a steal where the oldest is voice 2
        send_event("on71",       1'b1, 7'd71, 16'd6000);
        send_event("steal72",    1'b1, 7'd72, 16'd7000);

        // Panic during LOOKUP discards the in-flight note-on
        @(negedge clk);
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_number = 7'd77;
        note_period = 16'd777;
        @(negedge clk);
        note_valid    = 1'b0;
        all_notes_off = 1'b1;
        @(negedge clk);
        check("panic ready_held", note_ready, 0);
        m_active = '0;
        for (int i = 0; i < V; i++) m_age[i] = 0;
        check_model_state("panic");
        all_notes_off = 1'b0;
        #1;
        check("panic ready_idle", note_ready, 1);
        @(negedge clk);
        check_model_state("panic_after1");
        @(negedge clk);
        check_model_state("panic_after2");
        send_event("on74",       1'b1, 7'd74, 16'd8000);

        // Asynchronous reset during APPLY
        @(negedge clk);
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_number = 7'd90;
        note_period = 16'd1234;
        @(negedge clk);
        note_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_l = 1'b0;
        #1;
        model_reset();
        check("rst_async ready", note_ready, 1);
        check_model_state("rst_async");
        @(negedge clk);
        check_model_state("rst_held");
        reset_l = 1'b1;

        // Age saturation: voice 0 reaches the ceiling and must stay oldest
        send_event("sat_on10", 1'b1, 7'd10, 16'd100);
        send_event("sat_on20", 1'b1, 7'd20, 16'd200);
        for (int k = 0; k < 254; k++) begin
            send_event("sat_retrig20", 1'b1, 7'd20, 16'(200 + k));
        end
        send_event("sat_on30",    1'b1, 7'd30, 16'd300);
        send_event("sat_on40",    1'b1, 7'd40, 16'd400);
        send_event("sat_steal50", 1'b1, 7'd50, 16'd500);

        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter VOICES, default 4, sets the number of oscillator voices managed (2..16).
REQ-002 Parameter PERIOD_WIDTH, default CONFIG::PERIOD_WIDTH, sets the width of the oscillator period word.
REQ-003 Parameter AGE_WIDTH, default 8, sets the width of the per-voice saturating age counter.
REQ-004 Port clock_50_000_000  in  1  is the single system clock; all state changes on its rising edge.
REQ-005 Port reset_l  in  1  is the reset: asynchronous, active-low.
REQ-006 Port all_notes_off  in  1  is the synchronous panic: all voices released.
REQ-007 Port note_valid  in  1  indicates a note event is offered.
REQ-008 Port note_ready  out  1  indicates the block accepts an event this cycle.
REQ-009 Port note_on  in  1  is the event type: 1 = note-on, 0 = note-off.
REQ-010 Port note_number  in  7  is the MIDI note number.
REQ-011 Port note_period  in  PERIOD_WIDTH  is the oscillator period for the note; used only on note-on.
REQ-012 Port voice_active  out  VOICES  gives the per-voice sounding flag.
REQ-013 Port voice_note  out  VOICES x 7  gives the note held per voice.
REQ-014 Port voice_period  out  VOICES x PERIOD_WIDTH  gives the period driven to each oscillator.
REQ-015 Port voice_clear  out  VOICES  gives a one-cycle phase-restart pulse per oscillator.
REQ-016 Port steal  out  1  is a one-cycle pulse when an active voice is stolen.

Function
REQ-017 The FSM SHALL have states IDLE, LOOKUP and APPLY; note_ready = 1 only in IDLE.
REQ-018 Acceptance SHALL be note_valid && note_ready at an edge; event fields are latched and the state goes to LOOKUP.
REQ-019 LOOKUP SHALL register, in one cycle: the lowest-index active voice with matching note, the lowest-index inactive voice, and the active voice with largest age (lowest index on tie); then go to APPLY.
REQ-020 APPLY SHALL update the voice registers on its exit edge and return to IDLE; outputs change 2 edges after acceptance; the next acceptance is no earlier than 3 edges after the previous one.
REQ-021 A note-on with a matching voice SHALL retrigger that voice: load note_period, reset its age to 0 and pulse its voice_clear; steal stays 0.
REQ-022 A note-on with no match and a free voice SHALL assign the lowest-index free voice: set active, load note and period, reset its age to 0 and pulse its voice_clear.
REQ-023 A note-on with no match and no free voice SHALL assign the oldest voice, as in REQ-022, and pulse steal.
REQ-024 On every note-on commit, each other active voice's age SHALL increment, saturating at 2^AGE_WIDTH-1.
REQ-025 A note-off with a matching voice SHALL clear that voice's active flag; voice_note and voice_period hold; no voice_clear pulse.
REQ-026 A note-off with no match SHALL change no state other than the FSM.
REQ-027 voice_clear and steal SHALL be high only in the cycle following the APPLY exit edge.
REQ-028 all_notes_off SHALL have priority in any state: on the next edge, voice_active = 0, ages = 0, any in-flight event is discarded and the state becomes IDLE; note_ready stays 0 while all_notes_off = 1.
REQ-029 voice_period of an inactive voice SHALL retain its last value.

Reset
REQ-030 While reset_l = 0: state = IDLE, note_ready = 1, and voice_active, voice_note, voice_period, voice_clear, steal and ages are all 0.
REQ-031 Reset asserted mid-event SHALL discard the event with no partial voice update.

Verification
REQ-032 The bench SHALL cover: after reset, note-on 60 with period 1000 -> voice 0 active, note 60, period 1000; voice_clear = 0001 for 1 cycle; note_ready low for 2 cycles.
REQ-033 The bench SHALL cover: note-ons 60, 62, 64, 67 then note-on 69 -> voice 0 (oldest) gets 69; steal = 1 for 1 cycle; voice_clear = 0001.
REQ-034 The bench SHALL cover: with 60 in voice 0, note-on 60 with period 500 -> voice 0 retriggered with period 500; no new voice used; steal = 0.
REQ-035 The bench SHALL cover: note-off 62 with 62 in voice 1 -> voice_active[1] = 0, voice_period[1] unchanged; note-off 50 (absent) -> no change.
REQ-036 The bench SHALL cover: all_notes_off asserted during LOOKUP of a note-on -> next edge all voices inactive, the event is not applied, and the state is IDLE.
REQ-037 The bench SHALL cover: reset_l pulsed low during APPLY -> all outputs 0 immediately, asynchronously, and note_ready = 1.
